// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic MAC array: buffers K vectors of N lanes, then
// drives them out skewed so lane i trails lane 0 by i cycles.
module systolic_skew_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 4,
  parameter int unsigned K          = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic [N-1:0]            out_valid,
  output logic                    done,
  output logic                    busy
);

  localparam int unsigned STEPS = K + N - 1;
  localparam int unsigned LW    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned TW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {FILL, RUN} state_t;

  state_t                  state_q;
  logic [LW-1:0]           load_cnt;
  logic [TW-1:0]           t_q;
  logic [N*DATA_WIDTH-1:0] mem [K];
  logic [N-1:0]            step_valid;
  logic [N*DATA_WIDTH-1:0] step_data;

  // Tile buffer; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (state_q == FILL && in_valid) begin
      mem[load_cnt] <= in_data;
    end
  end

  // Diagonal selection for step t: lane i shows vector t-i while in range.
  always_comb begin
    step_valid = '0;
    step_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(t_q) >= i && 32'(t_q) < i + K) begin
        step_valid[i] = 1'b1;
        step_data[i*DATA_WIDTH +: DATA_WIDTH] =
          mem[LW'(32'(t_q) - i)][i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Control FSM with registered outputs; outputs default to idle every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      load_cnt  <= '0;
      t_q       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      done      <= 1'b0;
      out_valid <= '0;
      out_data  <= '0;
      case (state_q)
        FILL: begin
          if (in_valid) begin
            if (load_cnt == LW'(K - 1)) begin
              state_q  <= RUN;
              load_cnt <= '0;
              t_q      <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              load_cnt <= load_cnt + LW'(1);
            end
          end
        end
        RUN: begin
          out_valid <= step_valid;
          out_data  <= step_data;
          if (t_q == TW'(STEPS - 1)) begin
            done     <= 1'b1;
            state_q  <= FILL;
            t_q      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule
